// File: rtl/mem_responder.sv
// Memory-side responder for the p18240 bus: a word RAM behind re_L/we_L strobes with wait states.
// Define MEM_RESPONDER_MMIO_EN to map switches (16'hFFFE, read) and leds (16'hFFFF) into the space.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] memAddr,
  inout  wire  [15:0] dataBus,
  input  logic        re_L,
  input  logic        we_L,
  output logic        rdy,
  output logic        busErr,
  input  logic [15:0] switches,
  output logic [15:0] leds
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} stateT;

  stateT             state, nextState;
  logic [3:0]        waitCnt;
  logic [ADDR_W-1:0] capIdx;
  logic [15:0]       capData;
  logic [15:0]       rdData;
  logic              capRead;
  logic              capErr;
  logic              strobeErr;
  logic [15:0]       mem [0:(1<<ADDR_W)-1];

  logic              oneStrobe;
  logic              bothStrobes;
  logic              capture;
  logic              addrOob;
  logic              doneWrite;
  logic [15:0]       readValue;

  assign oneStrobe   = re_L ^ we_L;
  assign bothStrobes = !re_L && !we_L;
  assign capture     = (state == IDLE) && oneStrobe;

`ifdef MEM_RESPONDER_MMIO_EN
  logic        isSwAddr;
  logic        isLedAddr;
  logic        capMmio;
  logic        capLed;
  logic [15:0] ledsReg;

  assign isSwAddr  = memAddr == 16'hFFFE;
  assign isLedAddr = memAddr == 16'hFFFF;
  assign addrOob   = ((memAddr >> ADDR_W) != 16'h0) && !isSwAddr && !isLedAddr;

  always_comb begin
    readValue = mem[memAddr[ADDR_W-1:0]];
    if (isSwAddr)
      readValue = switches;
    else if (isLedAddr)
      readValue = ledsReg;
    else if (addrOob)
      readValue = 16'h0000;
  end

  // MMIO targets never touch the array; leds only change at the end of a DONE write
  always_ff @(posedge clock) begin
    if (reset) begin
      ledsReg <= 16'h0000;
      capMmio <= 1'b0;
      capLed  <= 1'b0;
    end else begin
      if (capture) begin
        capMmio <= isSwAddr || isLedAddr;
        capLed  <= isLedAddr;
      end
      if ((state == DONE) && !capRead && capLed)
        ledsReg <= capData;
    end
  end

  assign leds      = ledsReg;
  assign doneWrite = (state == DONE) && !capRead && !capErr && !capMmio;
`else
  logic unusedSwitches;

  assign unusedSwitches = ^switches;
  assign addrOob        = (memAddr >> ADDR_W) != 16'h0;
  assign readValue      = addrOob ? 16'h0000 : mem[memAddr[ADDR_W-1:0]];
  assign leds           = 16'h0000;
  assign doneWrite      = (state == DONE) && !capRead && !capErr;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      strobeErr <= 1'b0;
    end else begin
      state     <= nextState;
      strobeErr <= (state == IDLE) && bothStrobes;
      if (capture)
        waitCnt <= 4'(WAIT_CYCLES);
      else if (state == WAIT)
        waitCnt <= waitCnt - 4'd1;
    end
  end

  // Read data is registered at capture so it is already valid in the DONE cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (capture) begin
        capIdx  <= memAddr[ADDR_W-1:0];
        capData <= dataBus;
        capRead <= !re_L;
        capErr  <= addrOob;
        rdData  <= readValue;
      end else if ((state == IDLE) && bothStrobes) begin
        capRead <= 1'b0;
      end
      if (doneWrite)
        mem[capIdx] <= capData;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bothStrobes)
          nextState = HOLD;
        else if (oneStrobe)
          nextState = (WAIT_CYCLES == 0) ? DONE : WAIT;
      end
      WAIT:    if (waitCnt <= 4'd1) nextState = DONE;
      DONE:    nextState = HOLD;
      HOLD:    if (re_L && we_L) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign rdy     = state == DONE;
  assign busErr  = ((state == DONE) && capErr) || strobeErr;
  assign dataBus = (((state == DONE) || (state == HOLD)) && capRead && !re_L) ? rdData : 16'hzzzz;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (1, 0 and 3 wait states) checked against a
// transaction-level model of the array, error rules and MMIO registers.
module tb_mem_responder;

  localparam int DEPTH = 1024;

  logic        clock;
  logic        rst;
  logic [15:0] sw;
  logic [15:0] addr [3];
  logic        reL [3];
  logic        weL [3];
  logic [15:0] drv [3];
  logic        drvEn [3];
  logic        rdyS [3];
  logic        busErrS [3];
  logic [15:0] ledsS [3];
  wire  [15:0] bus0, bus1, bus2;

  int          waitOf [3] = '{1, 0, 3};
  logic [15:0] model [3][DEPTH];
  bit          known [3][DEPTH];
  logic [15:0] modelLeds [3];

  int          testCount = 0;
  int          failCount = 0;

  int          obsLat, obsRdyPulses, obsErrPulses;
  logic        obsErr, obsWaitDriven, obsHoldBad, obsRelZ;
  logic [15:0] obsData;

  assign bus0 = drvEn[0] ? drv[0] : 16'hzzzz;
  assign bus1 = drvEn[1] ? drv[1] : 16'hzzzz;
  assign bus2 = drvEn[2] ? drv[2] : 16'hzzzz;
  wire bus0Z = (bus0 === 16'hzzzz);
  wire bus1Z = (bus1 === 16'hzzzz);
  wire bus2Z = (bus2 === 16'hzzzz);

  mem_responder #(.WAIT_CYCLES(1)) dut0 (
    .clock(clock), .reset(rst), .memAddr(addr[0]), .dataBus(bus0), .re_L(reL[0]), .we_L(weL[0]),
    .rdy(rdyS[0]), .busErr(busErrS[0]), .switches(sw), .leds(ledsS[0]));
  mem_responder #(.WAIT_CYCLES(0)) dut1 (
    .clock(clock), .reset(rst), .memAddr(addr[1]), .dataBus(bus1), .re_L(reL[1]), .we_L(weL[1]),
    .rdy(rdyS[1]), .busErr(busErrS[1]), .switches(sw), .leds(ledsS[1]));
  mem_responder #(.WAIT_CYCLES(3)) dut2 (
    .clock(clock), .reset(rst), .memAddr(addr[2]), .dataBus(bus2), .re_L(reL[2]), .we_L(weL[2]),
    .rdy(rdyS[2]), .busErr(busErrS[2]), .switches(sw), .leds(ledsS[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit busIsZ(input int d);
    return (d == 0) ? bus0Z : (d == 1) ? bus1Z : bus2Z;
  endfunction

  function automatic logic [15:0] busVal(input int d);
    return (d == 0) ? bus0 : (d == 1) ? bus1 : bus2;
  endfunction

  // Reference model: what a transaction should return, and whether it is an error
  function automatic bit expErr(input logic [15:0] a);
`ifdef MEM_RESPONDER_MMIO_EN
    if (a == 16'hFFFE || a == 16'hFFFF) return 1'b0;
`endif
    return a >= DEPTH;
  endfunction

  function automatic bit expKnown(input int d, input logic [15:0] a);
    if (a >= DEPTH) return 1'b1;
    return known[d][a[9:0]];
  endfunction

  function automatic logic [15:0] expRead(input int d, input logic [15:0] a);
`ifdef MEM_RESPONDER_MMIO_EN
    if (a == 16'hFFFE) return sw;
    if (a == 16'hFFFF) return modelLeds[d];
`endif
    if (a >= DEPTH) return 16'h0000;
    return model[d][a[9:0]];
  endfunction

  task automatic modelWrite(input int d, input logic [15:0] a, input logic [15:0] v);
`ifdef MEM_RESPONDER_MMIO_EN
    if (a == 16'hFFFF) begin modelLeds[d] = v; return; end
    if (a == 16'hFFFE) return;
`endif
    if (a < DEPTH) begin
      model[d][a[9:0]] = v;
      known[d][a[9:0]] = 1'b1;
    end
  endtask

  // Runs one bus transaction and records what the DUT did; strobes held at least minHold edges
  task automatic applyStimulus(input int d, input bit isWrite, input logic [15:0] a,
                               input logic [15:0] v, input int minHold);
    bit released;
    obsLat = -1; obsRdyPulses = 0; obsErrPulses = 0; obsErr = 1'b0; obsData = 16'h0;
    obsWaitDriven = 1'b0; obsHoldBad = 1'b0; obsRelZ = 1'b1; released = 1'b0;
    @(negedge clock);
    addr[d] = a;
    if (isWrite) begin weL[d] = 1'b0; drv[d] = v; drvEn[d] = 1'b1; end
    else reL[d] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clock); #1;
      if (rdyS[d]) begin
        obsRdyPulses++;
        if (obsLat < 0) begin obsLat = k; obsErr = busErrS[d]; obsData = busVal(d); end
      end
      if (busErrS[d]) obsErrPulses++;
      if (!isWrite && !released) begin
        if (obsLat < 0 && !busIsZ(d)) obsWaitDriven = 1'b1;
        if (obsLat >= 0 && busVal(d) !== obsData) obsHoldBad = 1'b1;
      end
      @(negedge clock);
      if (k == 1) begin drvEn[d] = 1'b0; addr[d] = 16'($urandom); end
      if (!released && obsLat >= 0 && k >= minHold) begin
        reL[d] = 1'b1; weL[d] = 1'b1; released = 1'b1;
        #1 if (!isWrite && !busIsZ(d)) obsRelZ = 1'b0;
      end
      if (released && k >= obsLat + 3) break;
    end
    reL[d] = 1'b1; weL[d] = 1'b1; drvEn[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = 16'h0;
    for (int d = 0; d < 3; d++) begin
      addr[d] = 16'h0; reL[d] = 1'b1; weL[d] = 1'b1; drv[d] = 16'h0; drvEn[d] = 1'b0; modelLeds[d] = 16'h0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      testCount++; if (rdyS[d] !== 1'b0) begin failCount++; $display("[TB] FAIL reset rdy dut%0d: got %b need 0", d, rdyS[d]); end
      testCount++; if (busErrS[d] !== 1'b0) begin failCount++; $display("[TB] FAIL reset busErr dut%0d: got %b need 0", d, busErrS[d]); end
      testCount++; if (ledsS[d] !== 16'h0) begin failCount++; $display("[TB] FAIL reset leds dut%0d: got %h need 0000", d, ledsS[d]); end
      testCount++; if (!busIsZ(d)) begin failCount++; $display("[TB] FAIL reset bus dut%0d: got %h need zzzz", d, busVal(d)); end
    end
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    applyStimulus(0, 1'b1, 16'h0005, 16'hBEEF, 0);
    modelWrite(0, 16'h0005, 16'hBEEF);
    testCount++; if (obsLat !== 2) begin failCount++; $display("[TB] FAIL wr latency: got %0d need 2", obsLat); end
    testCount++; if (obsErr !== 1'b0) begin failCount++; $display("[TB] FAIL wr busErr: got %b need 0", obsErr); end
    applyStimulus(0, 1'b0, 16'h0005, 16'h0, 0);
    testCount++; if (obsLat !== 2) begin failCount++; $display("[TB] FAIL rd latency: got %0d need 2", obsLat); end
    testCount++; if (obsData !== 16'hBEEF) begin failCount++; $display("[TB] FAIL rd data: got %h need beef", obsData); end
    testCount++; if (obsWaitDriven !== 1'b0) begin failCount++; $display("[TB] FAIL rd bus during WAIT: driven=%b need 0", obsWaitDriven); end
    testCount++; if (obsRelZ !== 1'b1) begin failCount++; $display("[TB] FAIL rd release: highZ=%b need 1", obsRelZ); end
  endtask

  task automatic test_held_read();
    logic [15:0] v;
    v = 16'($urandom);
    applyStimulus(1, 1'b1, 16'h0003, v, 0);
    modelWrite(1, 16'h0003, v);
    applyStimulus(1, 1'b0, 16'h0003, 16'h0, 4);
    testCount++; if (obsLat !== 1) begin failCount++; $display("[TB] FAIL held latency: got %0d need 1", obsLat); end
    testCount++; if (obsRdyPulses !== 1) begin failCount++; $display("[TB] FAIL held rdy pulses: got %0d need 1", obsRdyPulses); end
    testCount++; if (obsData !== v) begin failCount++; $display("[TB] FAIL held data: got %h need %h", obsData, v); end
    testCount++; if (obsHoldBad !== 1'b0) begin failCount++; $display("[TB] FAIL held bus drive: unstable=%b need 0", obsHoldBad); end
    testCount++; if (obsRelZ !== 1'b1) begin failCount++; $display("[TB] FAIL held release: highZ=%b need 1", obsRelZ); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] v0;
    v0 = 16'($urandom);
    applyStimulus(0, 1'b1, 16'h0000, v0, 0);
    modelWrite(0, 16'h0000, v0);
    applyStimulus(0, 1'b0, 16'h0400, 16'h0, 0);
    testCount++; if (obsData !== 16'h0) begin failCount++; $display("[TB] FAIL oob rd data: got %h need 0000", obsData); end
    testCount++; if (obsErr !== 1'b1) begin failCount++; $display("[TB] FAIL oob rd busErr with rdy: got %b need 1", obsErr); end
    testCount++; if (obsErrPulses !== 1) begin failCount++; $display("[TB] FAIL oob rd busErr pulses: got %0d need 1", obsErrPulses); end
    applyStimulus(0, 1'b1, 16'h0400, ~v0, 0);
    testCount++; if (obsErr !== 1'b1) begin failCount++; $display("[TB] FAIL oob wr busErr: got %b need 1", obsErr); end
    applyStimulus(0, 1'b0, 16'h0000, 16'h0, 0);
    testCount++; if (obsData !== v0) begin failCount++; $display("[TB] FAIL oob wr corrupted array: got %h need %h", obsData, v0); end
  endtask

  task automatic test_both_strobes();
    int rdyCount;
    for (int d = 0; d < 2; d++) begin
      @(negedge clock);
      addr[d] = 16'h0005; reL[d] = 1'b0; weL[d] = 1'b0;
      @(posedge clock); #1;
      testCount++; if (busErrS[d] !== 1'b1) begin failCount++; $display("[TB] FAIL both busErr dut%0d: got %b need 1", d, busErrS[d]); end
      testCount++; if (rdyS[d] !== 1'b0) begin failCount++; $display("[TB] FAIL both rdy dut%0d: got %b need 0", d, rdyS[d]); end
      @(posedge clock); #1;
      testCount++; if (busErrS[d] !== 1'b0) begin failCount++; $display("[TB] FAIL both busErr width dut%0d: got %b need 0", d, busErrS[d]); end
      @(negedge clock);
      weL[d] = 1'b1;
      rdyCount = 0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clock); #1;
        if (rdyS[d] || !busIsZ(d)) rdyCount++;
      end
      testCount++; if (rdyCount !== 0) begin failCount++; $display("[TB] FAIL both held re_L activity dut%0d: got %0d cycles need 0", d, rdyCount); end
      @(negedge clock);
      reL[d] = 1'b1;
      applyStimulus(d, 1'b0, 16'h0005, 16'h0, 0);
      testCount++; if (obsLat !== waitOf[d] + 1) begin failCount++; $display("[TB] FAIL both back to IDLE dut%0d: latency %0d need %0d", d, obsLat, waitOf[d] + 1); end
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] prior;
    int rdyCount;
    prior = 16'($urandom) & 16'hEDCB;
    applyStimulus(2, 1'b1, 16'h0007, prior, 0);
    modelWrite(2, 16'h0007, prior);
    @(negedge clock);
    addr[2] = 16'h0007; weL[2] = 1'b0; drv[2] = 16'h1234; drvEn[2] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    drvEn[2] = 1'b0; weL[2] = 1'b1; rst = 1'b1;
    @(posedge clock); #1;
    for (int d = 0; d < 3; d++) modelLeds[d] = 16'h0;
    testCount++; if (rdyS[2] !== 1'b0) begin failCount++; $display("[TB] FAIL abort rdy: got %b need 0", rdyS[2]); end
    testCount++; if (!bus2Z) begin failCount++; $display("[TB] FAIL abort bus: got %h need zzzz", bus2); end
    @(negedge clock);
    rst = 1'b0;
    rdyCount = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      if (rdyS[2]) rdyCount++;
    end
    testCount++; if (rdyCount !== 0) begin failCount++; $display("[TB] FAIL abort late rdy: got %0d pulses need 0", rdyCount); end
    applyStimulus(2, 1'b0, 16'h0007, 16'h0, 0);
    testCount++; if (obsLat !== 4) begin failCount++; $display("[TB] FAIL abort reread latency: got %0d need 4", obsLat); end
    testCount++; if (obsData !== prior) begin failCount++; $display("[TB] FAIL abort write leaked: got %h need %h", obsData, prior); end
  endtask

  task automatic test_mmio();
    logic [15:0] ledsNeed, swNeed;
    logic        errNeed;
`ifdef MEM_RESPONDER_MMIO_EN
    ledsNeed = 16'h00A5; swNeed = 16'h5A5A; errNeed = 1'b0;
`else
    ledsNeed = 16'h0000; swNeed = 16'h0000; errNeed = 1'b1;
`endif
    applyStimulus(0, 1'b1, 16'hFFFF, 16'h00A5, 0);
    modelWrite(0, 16'hFFFF, 16'h00A5);
    testCount++; if (obsErr !== errNeed) begin failCount++; $display("[TB] FAIL mmio leds busErr: got %b need %b", obsErr, errNeed); end
    testCount++; if (ledsS[0] !== ledsNeed) begin failCount++; $display("[TB] FAIL mmio leds: got %h need %h", ledsS[0], ledsNeed); end
    sw = 16'h5A5A;
    applyStimulus(0, 1'b0, 16'hFFFE, 16'h0, 0);
    testCount++; if (obsData !== swNeed) begin failCount++; $display("[TB] FAIL mmio switches: got %h need %h", obsData, swNeed); end
    testCount++; if (obsErr !== errNeed) begin failCount++; $display("[TB] FAIL mmio switches busErr: got %b need %b", obsErr, errNeed); end
    applyStimulus(0, 1'b0, 16'hFFFF, 16'h0, 0);
    testCount++; if (obsData !== ledsNeed) begin failCount++; $display("[TB] FAIL mmio leds readback: got %h need %h", obsData, ledsNeed); end
  endtask

  task automatic test_random();
    logic [15:0] a, v, need;
    bit isWr, chk, err;
    int sel;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 25; n++) begin
        sel = $urandom_range(0, 9);
        if (sel <= 6) a = 16'($urandom_range(0, 15));
        else if (sel == 7) a = 16'($urandom_range(16'h0400, 16'hFFFD));
        else if (sel == 8) a = 16'hFFFE;
        else a = 16'hFFFF;
        isWr = 1'($urandom_range(0, 1));
        v = 16'($urandom);
        sw = 16'($urandom);
        need = expRead(d, a);
        chk = expKnown(d, a);
        err = expErr(a);
        applyStimulus(d, isWr, a, v, $urandom_range(0, 3));
        if (isWr) modelWrite(d, a, v);
        testCount++; if (obsLat !== waitOf[d] + 1) begin failCount++; $display("[TB] FAIL rand latency dut%0d a=%h: got %0d need %0d", d, a, obsLat, waitOf[d] + 1); end
        testCount++; if (obsRdyPulses !== 1) begin failCount++; $display("[TB] FAIL rand rdy pulses dut%0d a=%h: got %0d need 1", d, a, obsRdyPulses); end
        testCount++; if (obsErr !== err) begin failCount++; $display("[TB] FAIL rand busErr dut%0d a=%h: got %b need %b", d, a, obsErr, err); end
        testCount++; if (obsErrPulses !== int'(err)) begin failCount++; $display("[TB] FAIL rand busErr pulses dut%0d a=%h: got %0d need %0d", d, a, obsErrPulses, int'(err)); end
        if (!isWr && chk) begin
          testCount++; if (obsData !== need) begin failCount++; $display("[TB] FAIL rand rd data dut%0d a=%h: got %h need %h", d, a, obsData, need); end
        end
        if (!isWr) begin
          testCount++; if (obsWaitDriven !== 1'b0 || obsRelZ !== 1'b1) begin failCount++; $display("[TB] FAIL rand bus drive dut%0d a=%h: waitDriven=%b releaseZ=%b need 0/1", d, a, obsWaitDriven, obsRelZ); end
        end
        testCount++; if (ledsS[d] !== modelLeds[d]) begin failCount++; $display("[TB] FAIL rand leds dut%0d: got %h need %h", d, ledsS[d], modelLeds[d]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_held_read();
    test_out_of_range();
    test_both_strobes();
    test_reset_abort();
    test_mmio();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", testCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
